password_access_ctrl: RTL and testbench
=======================================

PASSWORD_ACCESS_CTRL -- requirements
Module: password_access_ctrl

Interface
REQ-001 Parameter PW_LEN, default 4, password length in bytes (legal 1..10).
REQ-002 Parameter MAX_FAIL, default 3, consecutive failed verifies that trigger lockout.
REQ-003 Parameter LOCK_CYCLES, default 16, lockout duration in clk cycles.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req_enroll, input, 1: request to store a new password.
REQ-007 Port req_verify, input, 1: request to check a candidate password.
REQ-008 Port byte_valid, input, 1: byte_data is valid.
REQ-009 Port byte_data, input, 8: password byte, first byte first.
REQ-010 Port byte_ready, output, 1: block accepts a byte this cycle.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: one-cycle pulse at operation end.
REQ-013 Port match, output, 1: verify result, held until the next done.
REQ-014 Port locked, output, 1: lockout active.
REQ-015 Ports mem_write_en (1), mem_write_addr (4), mem_write_data (8), mem_read_addr (4): outputs to the 10x8 storage.
REQ-016 Port mem_read_data, input, 8: combinational read data from storage.

Function
REQ-017 States IDLE, ENROLL, VERIFY, RESULT, LOCKED; 4-bit index counter idx; sticky mismatch flag.
REQ-018 IDLE: req_verify -> VERIFY; req_enroll alone -> ENROLL; both high -> VERIFY wins; idx and mismatch cleared on entry.
REQ-019 byte_ready = 1 only in ENROLL and VERIFY; byte accepted when byte_valid && byte_ready.
REQ-020 ENROLL: mem_write_en = accept, mem_write_addr = idx, mem_write_data = byte_data, all combinational same cycle.
REQ-021 VERIFY: mem_read_addr = idx; on accept, mismatch |= (byte_data != mem_read_data); mem_write_en = 0.
REQ-022 Outside VERIFY mem_read_addr = 0; outside ENROLL mem_write_en = 0, mem_write_addr = 0, mem_write_data = 0.
REQ-023 idx increments on each accept; accept at idx = PW_LEN-1 -> RESULT next cycle; idx never exceeds PW_LEN-1.
REQ-024 byte_valid low stalls indefinitely with no state change; requests ignored outside IDLE.
REQ-025 RESULT lasts exactly one cycle: done = 1; match registered = (VERIFY and final mismatch == 0); enroll gives match = 0.
REQ-026 Failed verify increments fail_cnt (saturating at MAX_FAIL); passed verify clears fail_cnt; enroll leaves it unchanged.
REQ-027 RESULT -> LOCKED if fail_cnt reaches MAX_FAIL this cycle, else IDLE.
REQ-028 LOCKED: locked = 1, requests ignored, lock counter runs LOCK_CYCLES cycles, then IDLE with fail_cnt cleared and locked = 0.
REQ-029 Latency: last byte accepted in cycle N -> done in cycle N+1 -> IDLE (or LOCKED) in N+2.

Reset
REQ-030 rst_n low at any time forces IDLE; idx, mismatch, fail_cnt, lock counter = 0.
REQ-031 Reset values: byte_ready 0, busy 0, done 0, match 0, locked 0, all mem_* outputs 0.
REQ-032 Reset mid-ENROLL aborts; bytes already written stay in storage; no done pulse.

Configuration
REQ-033 Macro PASSWORD_LOCKOUT_EN defined: fail_cnt, LOCKED state and lock counter present per REQ-026..028.
REQ-034 Macro undefined: no fail counter or LOCKED state, RESULT always -> IDLE, locked tied 0, MAX_FAIL/LOCK_CYCLES unused.

Verification
REQ-035 Enroll 0x12,0x34,0x56,0x78 -> mem writes at addr 0..3 in 4 accept cycles, done one cycle after last, match 0.
REQ-036 After REQ-035, verify 0x12,0x34,0x56,0x78 with byte_valid gaps -> done, match 1, fail_cnt 0.
REQ-037 Verify 0x12,0x34,0x56,0x79 -> done, match 0; first-byte mismatch also yields match 0.
REQ-038 Three failed verifies (lockout enabled) -> locked 1 for 16 cycles, req_verify ignored, then IDLE, next correct verify gives match 1.
REQ-039 req_enroll and req_verify same cycle in IDLE -> VERIFY entered, no mem writes.
REQ-040 rst_n low after 2 enroll bytes -> outputs at reset values immediately, addr 0..1 hold new data, no done.

Source files
------------

// File: rtl/password_access_ctrl.sv
// Password enroll/verify controller driving an external 10x8 byte store.
// Optional lockout after repeated failed verifies: define PASSWORD_LOCKOUT_EN.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | waiting for req_verify (priority) or req_enroll
//  ENROLL   | accepting bytes, writing each to storage at idx
//  VERIFY   | accepting bytes, comparing each with storage at idx
//  RESULT   | one-cycle done pulse, match valid
//  LOCKED   | lockout timer running, requests ignored (lockout build only)
module password_access_ctrl #(
  parameter int PW_LEN      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_enroll_i,
  input  logic       req_verify_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       match_o,
  output logic       locked_o,
  output logic       mem_write_en_o,
  output logic [3:0] mem_write_addr_o,
  output logic [7:0] mem_write_data_o,
  output logic [3:0] mem_read_addr_o,
  input  logic [7:0] mem_read_data_i
);

  localparam logic [3:0] LAST_IDX = 4'(PW_LEN - 1);

`ifdef PASSWORD_LOCKOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_ENROLL, S_VERIFY, S_RESULT, S_LOCKED} state_t;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [FW-1:0] MAX_F     = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_ENROLL, S_VERIFY, S_RESULT} state_t;
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_FAIL), 32'(LOCK_CYCLES)};
`endif

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       mismatch_q, mismatch_d;
  logic       verify_q, verify_d;
  logic       match_q, match_d;
  logic       accept;

  assign byte_ready_o     = (state_q == S_ENROLL) || (state_q == S_VERIFY);
  assign accept           = byte_valid_i && byte_ready_o;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_RESULT);
  assign match_o          = match_q;
  assign mem_write_en_o   = (state_q == S_ENROLL) && accept;
  assign mem_write_addr_o = (state_q == S_ENROLL) ? idx_q : 4'd0;
  assign mem_write_data_o = (state_q == S_ENROLL) ? byte_data_i : 8'd0;
  assign mem_read_addr_o  = (state_q == S_VERIFY) ? idx_q : 4'd0;
`ifdef PASSWORD_LOCKOUT_EN
  assign locked_o         = (state_q == S_LOCKED);
`else
  assign locked_o         = 1'b0;
`endif

  // Next-state logic: byte sequencing, sticky compare, result and lockout.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    verify_d   = verify_q;
    match_d    = match_q;
`ifdef PASSWORD_LOCKOUT_EN
    fail_d     = fail_q;
    lock_d     = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_verify_i || req_enroll_i) begin
          state_d    = req_verify_i ? S_VERIFY : S_ENROLL;
          verify_d   = req_verify_i;
          idx_d      = 4'd0;
          mismatch_d = 1'b0;
        end
      end
      S_ENROLL, S_VERIFY: begin
        if (accept) begin
          if (state_q == S_VERIFY) begin
            mismatch_d = mismatch_q | (byte_data_i != mem_read_data_i);
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_RESULT;
            // Latched on the way into RESULT so it is valid with done.
            match_d = verify_q & ~mismatch_d;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_RESULT: begin
        state_d = S_IDLE;
`ifdef PASSWORD_LOCKOUT_EN
        if (verify_q) begin
          if (match_q) begin
            fail_d = '0;
          end else if (fail_q != MAX_F) begin
            fail_d = fail_q + FW'(1);
          end
        end
        if (fail_d == MAX_F) begin
          state_d = S_LOCKED;
          lock_d  = LOCK_LOAD;
        end
`endif
      end
`ifdef PASSWORD_LOCKOUT_EN
      S_LOCKED: begin
        if (lock_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          lock_d = lock_q - LW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      mismatch_q <= 1'b0;
      verify_q   <= 1'b0;
      match_q    <= 1'b0;
`ifdef PASSWORD_LOCKOUT_EN
      fail_q     <= '0;
      lock_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      verify_q   <= verify_d;
      match_q    <= match_d;
`ifdef PASSWORD_LOCKOUT_EN
      fail_q     <= fail_d;
      lock_q     <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_password_access_ctrl.sv
// Directed bench for password_access_ctrl with a behavioural 10x8 byte store.
module tb_password_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_enroll, req_verify, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, busy, done, match, locked;
  logic       mem_write_en;
  logic [3:0] mem_write_addr, mem_read_addr;
  logic [7:0] mem_write_data, mem_read_data;

  logic [7:0] mem [0:15];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  password_access_ctrl #(.PW_LEN(4), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .req_enroll_i     (req_enroll),
    .req_verify_i     (req_verify),
    .byte_valid_i     (byte_valid),
    .byte_data_i      (byte_data),
    .byte_ready_o     (byte_ready),
    .busy_o           (busy),
    .done_o           (done),
    .match_o          (match),
    .locked_o         (locked),
    .mem_write_en_o   (mem_write_en),
    .mem_write_addr_o (mem_write_addr),
    .mem_write_data_o (mem_write_data),
    .mem_read_addr_o  (mem_read_addr),
    .mem_read_data_i  (mem_read_data)
  );

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
  end

  // Stimulus only: issue a verify of four bytes, optionally with a one-cycle
  // byte_valid gap before every odd byte; returns done/match one cycle after
  // the last accept.
  task automatic run_verify(input logic [7:0] b0, b1, b2, b3, input bit gaps,
                            output logic got_done, output logic got_match);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    @(negedge clk);
    req_verify = 1'b1;
    @(negedge clk);
    req_verify = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps && (i % 2 == 1)) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b[i];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    got_done   = done;
    got_match  = match;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, busy, done, match, locked, mem_write_en, mem_write_addr,
         mem_write_data, mem_read_addr} !== 23'd0)
      $display("FAIL reset_outputs: got %b want all zero",
               {byte_ready, busy, done, match, locked, mem_write_en,
                mem_write_addr, mem_write_data, mem_read_addr});
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_enroll;
    logic [7:0] pw [4];
    bit bad_wr;
    pw[0] = 8'h12; pw[1] = 8'h34; pw[2] = 8'h56; pw[3] = 8'h78;
    bad_wr = 1'b0;
    @(negedge clk);
    req_enroll = 1'b1;
    @(negedge clk);
    req_enroll = 1'b0;
    checks++;
    if ({busy, byte_ready} !== 2'b11)
      $display("FAIL enroll_entry: busy,ready=%b want 11", {busy, byte_ready});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data  = pw[i];
      #1;
      if (mem_write_en !== 1'b1 || mem_write_addr !== 4'(i) || mem_write_data !== pw[i]) begin
        bad_wr = 1'b1;
        $display("FAIL enroll_write%0d: en=%b addr=%0d data=%h want 1/%0d/%h",
                 i, mem_write_en, mem_write_addr, mem_write_data, i, pw[i]);
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (!bad_wr) passed++;
    checks++;
    if ({done, match, busy} !== 3'b101)
      $display("FAIL enroll_done: done,match,busy=%b want 101", {done, match, busy});
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00)
      $display("FAIL enroll_back_idle: done,busy=%b want 00", {done, busy});
    else passed++;
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h12345678)
      $display("FAIL enroll_storage: got %h want 12345678",
               {mem[0], mem[1], mem[2], mem[3]});
    else passed++;
  endtask

  task automatic test_verify_pass;
    logic d, m;
    run_verify(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, d, m);
    checks++;
    if ({d, m} !== 2'b11) $display("FAIL verify_pass: done,match=%b want 11", {d, m});
    else passed++;
    @(negedge clk);
    checks++;
    if ({busy, match} !== 2'b01)
      $display("FAIL verify_match_held: busy,match=%b want 01", {busy, match});
    else passed++;
  endtask

  task automatic test_verify_fail_last;
    logic d, m;
    run_verify(8'h12, 8'h34, 8'h56, 8'h79, 1'b0, d, m);
    checks++;
    if ({d, m} !== 2'b10) $display("FAIL verify_bad_last: done,match=%b want 10", {d, m});
    else passed++;
  endtask

  task automatic test_verify_fail_first;
    logic d, m;
    run_verify(8'h13, 8'h34, 8'h56, 8'h78, 1'b0, d, m);
    checks++;
    if ({d, m} !== 2'b10) $display("FAIL verify_bad_first: done,match=%b want 10", {d, m});
    else passed++;
  endtask

`ifdef PASSWORD_LOCKOUT_EN
  task automatic test_lockout;
    logic d, m;
    bit bad_lock;
    bad_lock = 1'b0;
    run_verify(8'h00, 8'h34, 8'h56, 8'h78, 1'b0, d, m);
    checks++;
    if ({d, m, locked} !== 3'b100)
      $display("FAIL lock_third_fail: done,match,locked=%b want 100", {d, m, locked});
    else passed++;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if ({locked, busy, byte_ready} !== 3'b110) begin
        bad_lock = 1'b1;
        $display("FAIL lock_cycle%0d: locked,busy,ready=%b want 110", k,
                 {locked, busy, byte_ready});
      end
      req_verify = (k < 16);
    end
    checks++;
    if (!bad_lock) passed++;
    @(negedge clk);
    checks++;
    if ({locked, busy} !== 2'b00)
      $display("FAIL lock_release: locked,busy=%b want 00", {locked, busy});
    else passed++;
    run_verify(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, d, m);
    checks++;
    if ({d, m} !== 2'b11) $display("FAIL verify_after_lock: done,match=%b want 11", {d, m});
    else passed++;
  endtask
`else
  task automatic test_no_lockout;
    logic d, m;
    run_verify(8'h00, 8'h34, 8'h56, 8'h78, 1'b0, d, m);
    checks++;
    if ({d, m, locked} !== 3'b100)
      $display("FAIL nolock_third_fail: done,match,locked=%b want 100", {d, m, locked});
    else passed++;
    @(negedge clk);
    checks++;
    if ({locked, busy} !== 2'b00)
      $display("FAIL nolock_idle: locked,busy=%b want 00", {locked, busy});
    else passed++;
  endtask
`endif

  task automatic test_both_requests;
    logic [7:0] pw [4];
    bit bad_rd;
    pw[0] = 8'h12; pw[1] = 8'h34; pw[2] = 8'h56; pw[3] = 8'h78;
    bad_rd = 1'b0;
    @(negedge clk);
    req_enroll = 1'b1;
    req_verify = 1'b1;
    @(negedge clk);
    req_enroll = 1'b0;
    req_verify = 1'b0;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data  = pw[i];
      #1;
      if (mem_write_en !== 1'b0 || mem_read_addr !== 4'(i) || byte_ready !== 1'b1) begin
        bad_rd = 1'b1;
        $display("FAIL both_req_byte%0d: wen=%b raddr=%0d ready=%b want 0/%0d/1",
                 i, mem_write_en, mem_read_addr, byte_ready, i);
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (!bad_rd) passed++;
    checks++;
    if ({done, match} !== 2'b11)
      $display("FAIL both_req_result: done,match=%b want 11", {done, match});
    else passed++;
  endtask

  task automatic test_reset_mid_enroll;
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    req_enroll = 1'b1;
    @(negedge clk);
    req_enroll = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hA1;
    @(negedge clk);
    byte_data  = 8'hB2;
    @(negedge clk);
    byte_data  = 8'hC3;
    #1;
    checks++;
    if ({mem_write_en, mem_write_addr} !== 5'b1_0010)
      $display("FAIL mid_enroll_third: en,addr=%b want 10010", {mem_write_en, mem_write_addr});
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, busy, done, match, locked, mem_write_en, mem_write_addr,
         mem_write_data, mem_read_addr} !== 23'd0)
      $display("FAIL mid_enroll_reset: got %b want all zero",
               {byte_ready, busy, done, match, locked, mem_write_en,
                mem_write_addr, mem_write_data, mem_read_addr});
    else passed++;
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b1;
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hA1B25678)
      $display("FAIL mid_enroll_storage: got %h want a1b25678",
               {mem[0], mem[1], mem[2], mem[3]});
    else passed++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) $display("FAIL mid_enroll_no_done: done or busy seen after abort, want none");
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n      = 1'b0;
    req_enroll = 1'b0;
    req_verify = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset;
    test_enroll;
    test_verify_pass;
    test_verify_fail_last;
    test_verify_fail_first;
`ifdef PASSWORD_LOCKOUT_EN
    test_lockout;
`else
    test_no_lockout;
`endif
    test_both_requests;
    test_reset_mid_enroll;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
